time_entry_ctrl: RTL

Keypad-driven time-setting controller that produces the load interface consumed by the clock's counting logic. It collects four BCD digits and an AM/PM flag from single-cycle key strobes, validates each digit against 12-hour clock rules, and issues a one-cycle load pulse carrying a legal time. It sits between the keypad scanner and the counting logic and is the sole writer of the `new_current_time_*` bus and `load_new_c`.

---
 rtl/clock_pkg.sv | 37 +++
 rtl/entry_timeout.sv | 29 ++
 rtl/time_entry_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared key codes, entry states and digit limits for the clock
package clock_pkg;

    localparam logic [3:0] KEY_AMPM    = 4'hA;
    localparam logic [3:0] KEY_CANCEL  = 4'hB;
    localparam logic [3:0] KEY_ENTER   = 4'hC;
    localparam logic [3:0] KEY_SET     = 4'hD;

    localparam logic [3:0] MS_HR_MAX   = 4'd1;
    localparam logic [3:0] MS_MIN_MAX  = 4'd5;
    localparam logic [3:0] HR12_LS_MAX = 4'd2;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D0,
        ST_D1,
        ST_D2,
        ST_D3,
        ST_READY
    } entry_state_t;

    // 12-hour legality of a digit for the slot the entry is waiting on
    function automatic logic digit_ok(input entry_state_t st, input logic [3:0] d,
                                      input logic [3:0] ms_hr);
        logic ok;
        case (st)
            ST_D0:   ok = (d <= MS_HR_MAX);
            ST_D1:   ok = (ms_hr == 4'd0) ? (d != 4'd0 && d <= DIGIT_MAX) : (d <= HR12_LS_MAX);
            ST_D2:   ok = (d <= MS_MIN_MAX);
            ST_D3:   ok = (d <= DIGIT_MAX);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/entry_timeout.sv
// rtl/entry_timeout.sv - one_second tick counter that flags an abandoned entry
module entry_timeout #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    logic [7:0] count;

    // A key in the same cycle as the final tick suppresses expiry
    assign expired = enable && tick && !clear && (count == 8'(TIMEOUT_TICKS - 1));

    // Count ticks while an entry is open; restart on keys, expiry or leaving entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear || !enable || expired) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/time_entry_ctrl.sv
// rtl/time_entry_ctrl.sv - keypad time entry FSM producing the counter load interface
module time_entry_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_strobe,
    input  logic       one_second,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       new_current_time_AM,
    output logic       load_new_c,
    output logic       entry_active,
    output logic [1:0] entry_pos,
    output logic       key_error,
    output logic       entry_timeout
);
    import clock_pkg::*;

    entry_state_t state, state_next;
    logic [3:0]   ms_hr_next, ls_hr_next, ms_min_next, ls_min_next;
    logic         am_next, load_next, err_next, tmo_next;
    logic         key_valid, tmr_clear, expired;

    // E and F never count as keys, so they neither restart nor block the timeout
    assign key_valid = key_strobe && (key_code <= KEY_SET);
    assign tmr_clear = key_valid && (state != ST_IDLE);

    entry_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (state != ST_IDLE),
        .tick    (one_second),
        .expired (expired)
    );

    // Next state, buffer updates and pulse requests for this cycle's key or tick
    always_comb begin
        state_next  = state;
        ms_hr_next  = new_current_time_ms_hr;
        ls_hr_next  = new_current_time_ls_hr;
        ms_min_next = new_current_time_ms_min;
        ls_min_next = new_current_time_ls_min;
        am_next     = new_current_time_AM;
        load_next   = 1'b0;
        err_next    = 1'b0;
        tmo_next    = 1'b0;
        if (key_valid) begin
            if (key_code == KEY_SET) begin
                state_next  = ST_D0;
                ms_hr_next  = 4'd0;
                ls_hr_next  = 4'd0;
                ms_min_next = 4'd0;
                ls_min_next = 4'd0;
            end else if (state != ST_IDLE) begin
                if (key_code <= DIGIT_MAX) begin
                    if (digit_ok(state, key_code, new_current_time_ms_hr)) begin
                        case (state)
                            ST_D0:   begin ms_hr_next  = key_code; state_next = ST_D1;    end
                            ST_D1:   begin ls_hr_next  = key_code; state_next = ST_D2;    end
                            ST_D2:   begin ms_min_next = key_code; state_next = ST_D3;    end
                            default: begin ls_min_next = key_code; state_next = ST_READY; end
                        endcase
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (key_code == KEY_AMPM) begin
                    am_next = ~new_current_time_AM;
                end else if (key_code == KEY_CANCEL) begin
                    state_next = ST_IDLE;
                end else if (state == ST_READY) begin
                    load_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    err_next = 1'b1;
                end
            end
        end else if (expired) begin
            state_next = ST_IDLE;
            tmo_next   = 1'b1;
        end
    end

    // State, entry buffer and one-cycle pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= ST_IDLE;
            new_current_time_ms_hr  <= 4'd0;
            new_current_time_ls_hr  <= 4'd0;
            new_current_time_ms_min <= 4'd0;
            new_current_time_ls_min <= 4'd0;
            new_current_time_AM     <= 1'b0;
            load_new_c              <= 1'b0;
            key_error               <= 1'b0;
            entry_timeout           <= 1'b0;
        end else begin
            state                   <= state_next;
            new_current_time_ms_hr  <= ms_hr_next;
            new_current_time_ls_hr  <= ls_hr_next;
            new_current_time_ms_min <= ms_min_next;
            new_current_time_ls_min <= ls_min_next;
            new_current_time_AM     <= am_next;
            load_new_c              <= load_next;
            key_error               <= err_next;
            entry_timeout           <= tmo_next;
        end
    end

    // Entry status decoded from the state register
    always_comb begin
        entry_active = (state != ST_IDLE);
        case (state)
            ST_D1:   entry_pos = 2'd1;
            ST_D2:   entry_pos = 2'd2;
            ST_D3:   entry_pos = 2'd3;
            default: entry_pos = 2'd0;
        endcase
    end

endmodule
